run_hls_deadlock_report_ctrl: RTL
=================================

Name: run_hls_deadlock_report_ctrl

Overview:
- Central sequencer for the per-process deadlock detect units of one dataflow region.
- Collects every unit's dl_detect_out and elects one origin process.
- Broadcasts the sticky global detect flag, walks the dependency-cycle token around the ring, and streams the ids of the processes in the cycle.
- Ends the walk with token_clear and holds a final report until it is acknowledged.

Parameters:
- PROC_NUM, 4: number of processes and detect units.
- PROC_ID_W, 2: width of a process id, equal to ceil(log2(PROC_NUM)) with a minimum of 1.
- TIMEOUT, 64: number of TRACE cycles allowed with no newly visited process before the walk aborts.
- TIMEOUT_W, 7: width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- dl_detect_vec  in  PROC_NUM  per-unit dl_detect_out.
- token_seen_vec  in  PROC_NUM  per-unit OR of token_in_vec.
- dl_detect_global  out  1  drives dl_detect_in of every unit.
- origin_vec  out  PROC_NUM  one-hot origin strobe to the units.
- token_clear  out  1  broadcast token clear.
- report_valid  out  1  report stream valid.
- report_ready  in  1  report stream ready.
- report_proc_id  out  PROC_ID_W  id of a process in the cycle.
- report_done  out  1  walk finished; held until acknowledged.
- report_timeout  out  1  walk aborted by timeout; qualified by report_done.
- report_cycle_mask  out  PROC_NUM  all visited processes; valid while report_done.
- report_ack  in  1  releases the report; return to IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal masks and counter 0. Reset has priority over all other inputs, including mid-walk.
- IDLE:
  - Entered on any bit of dl_detect_vec.
  - Latch org = lowest set index; simultaneous detects resolve to the lowest index.
  - Next cycle: ORIGIN.
- ORIGIN (exactly 1 cycle):
  - origin_vec = 1<<org.
  - dl_detect_global = 1; it stays 1 until report_ack or reset.
  - visited = 1<<org; clear tcnt.
  - Next cycle: TRACE.
- TRACE:
  - Each cycle: new = token_seen_vec & ~visited; visited |= token_seen_vec.
  - tcnt is cleared when new≠0 and incremented otherwise.
  - Cycle closed when token_seen_vec[org]=1 in a TRACE cycle, giving CLEAR. A token returning in the first TRACE cycle (self-loop) also counts.
  - tcnt==TIMEOUT-1 with new==0 gives CLEAR and sets timeout_flag.
  - Closure and timeout in the same cycle: closure wins and timeout_flag stays 0.
  - Tokens seen in the closing cycle are still merged into visited.
- CLEAR (exactly 1 cycle):
  - token_clear=1.
  - token_seen_vec is ignored from this state until IDLE.
  - Next cycle: DRAIN.
- Report stream, active in TRACE, CLEAR and DRAIN:
  - pending = visited & ~reported.
  - report_valid = |pending, registered.
  - report_proc_id = lowest set index of pending.
  - On valid&ready, set that bit in reported; at most one transfer per cycle.
  - valid/id stay stable until accepted; id may change only after acceptance.
  - The origin is always reported first because it is set in ORIGIN.
- DRAIN:
  - When pending==0 and no transfer is in flight, go to DONE.
- DONE:
  - report_done=1.
  - report_cycle_mask=visited.
  - report_timeout=timeout_flag.
  - On report_ack: clear masks, flag and outputs, and return to IDLE.
  - report_ack in any other state is ignored.
- dl_detect_vec is ignored outside IDLE.
- Latency:
  - origin_vec is asserted 1 cycle after dl_detect_vec is seen in IDLE.
  - First report_valid comes 1 cycle after ORIGIN.
  - token_clear comes 1 cycle after closure.

Decomposition:
- Package run_hls_deadlock_pkg holds:
  - FSM state enum: IDLE, ORIGIN, TRACE, CLEAR, DRAIN, DONE.
  - clog2-style width function.
- One sub-module, run_hls_lowest_bit_enc: parameterised priority encoder returning a PROC_ID_W index and a found flag. It is used both for origin election and for picking the report id.

Test Plan:
- PROC_NUM=4, dl_detect_vec=0b0100, then token_seen 0b0010, 0b1000, 0b0100 on consecutive TRACE cycles, report_ready=1 → origin_vec=0b0100 for one cycle; reported ids 2,1,3; token_clear one cycle after the 0b0100 token; report_cycle_mask=0b1110; report_timeout=0.
- dl_detect_vec=0b1010 in the same cycle → origin_vec=0b0010; id 1 reported first.
- Self-loop: detect 0b0001, then token_seen=0b0001 in the first TRACE cycle → CLEAR next cycle; single id 0; mask 0b0001.
- No tokens after ORIGIN with TIMEOUT=8 → CLEAR after 8 TRACE cycles; report_done with report_timeout=1; mask equals the origin bit.
- report_ready held 0 for 5 cycles during a 3-process walk → valid/id stable while stalled; DONE only after all 3 ids accepted.
- reset=1 asserted in TRACE → next cycle all outputs 0 and FSM in IDLE; a new detect then restarts the walk cleanly.
- Bonus check: report_ack in DONE → dl_detect_global=0 the next cycle.

Source files
------------

// File: rtl/run_hls_deadlock_pkg.sv
// ============================================================================
// run_hls_deadlock_pkg
// Shared state encoding and width helper for the deadlock report controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package run_hls_deadlock_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ORIGIN = 3'd1,
        TRACE  = 3'd2,
        CLEAR  = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // ceil(log2(n)), never less than 1
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_hls_lowest_bit_enc.sv
// ============================================================================
// run_hls_lowest_bit_enc
// Priority encoder: index of the lowest set bit plus a found flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module run_hls_lowest_bit_enc
    import run_hls_deadlock_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top so the last hit written is the lowest index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/run_hls_deadlock_report_ctrl.sv
// ============================================================================
// run_hls_deadlock_report_ctrl
// Elects a deadlock origin, walks the cycle token and streams the visited ids.
// Rev 1.0
// ============================================================================
`default_nettype none

module run_hls_deadlock_report_ctrl
    import run_hls_deadlock_pkg::*;
#(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = 2,
    parameter int TIMEOUT   = 64,
    parameter int TIMEOUT_W = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PROC_NUM-1:0]  dl_detect_vec,
    input  logic [PROC_NUM-1:0]  token_seen_vec,
    output logic                 dl_detect_global,
    output logic [PROC_NUM-1:0]  origin_vec,
    output logic                 token_clear,
    output logic                 report_valid,
    input  logic                 report_ready,
    output logic [PROC_ID_W-1:0] report_proc_id,
    output logic                 report_done,
    output logic                 report_timeout,
    output logic [PROC_NUM-1:0]  report_cycle_mask,
    input  logic                 report_ack
);

    state_t                r_state;
    logic [PROC_ID_W-1:0]  r_org;
    logic [PROC_NUM-1:0]   r_visited;
    logic [PROC_NUM-1:0]   r_reported;
    logic [TIMEOUT_W-1:0]  r_tcnt;
    logic                  r_timeout_flag;
    logic                  r_dl_global;
    logic [PROC_NUM-1:0]   r_origin_vec;
    logic                  r_token_clear;
    logic                  r_valid;
    logic [PROC_ID_W-1:0]  r_id;
    logic                  r_done;
    logic                  r_timeout;
    logic [PROC_NUM-1:0]   r_mask;

    logic [PROC_ID_W-1:0]  w_org_idx;
    logic                  w_org_found;
    logic [PROC_NUM-1:0]   w_org_onehot;
    logic [PROC_NUM-1:0]   w_id_onehot;
    logic                  w_tracing;
    logic                  w_stream;
    logic [PROC_NUM-1:0]   w_seen;
    logic [PROC_NUM-1:0]   w_new;
    logic [PROC_NUM-1:0]   w_visited_nxt;
    logic [PROC_NUM-1:0]   w_reported_nxt;
    logic [PROC_NUM-1:0]   w_pending;
    logic [PROC_NUM-1:0]   w_pending_nxt;
    logic [PROC_ID_W-1:0]  w_pick_idx;
    logic                  w_pick_found;
    logic                  w_closed;
    logic                  w_expired;

    run_hls_lowest_bit_enc #(.WIDTH(PROC_NUM), .IDX_W(PROC_ID_W)) u_origin_enc (
        .i_vec   (dl_detect_vec),
        .o_idx   (w_org_idx),
        .o_found (w_org_found)
    );

    run_hls_lowest_bit_enc #(.WIDTH(PROC_NUM), .IDX_W(PROC_ID_W)) u_report_enc (
        .i_vec   (w_pending_nxt),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_org_onehot            = '0;
        w_org_onehot[w_org_idx] = 1'b1;
        w_id_onehot             = '0;
        w_id_onehot[r_id]       = 1'b1;
    end

    // Tokens only count while tracing; afterwards the ring is being cleared.
    assign w_tracing      = (r_state == TRACE);
    assign w_stream       = (r_state == ORIGIN) || (r_state == TRACE) ||
                            (r_state == CLEAR)  || (r_state == DRAIN);
    assign w_seen         = w_tracing ? token_seen_vec : '0;
    assign w_new          = w_seen & ~r_visited;
    assign w_visited_nxt  = r_visited | w_seen;
    assign w_reported_nxt = r_reported | ((r_valid && report_ready) ? w_id_onehot : '0);
    assign w_pending      = r_visited & ~r_reported;
    assign w_pending_nxt  = w_visited_nxt & ~w_reported_nxt;
    assign w_closed       = w_tracing && token_seen_vec[r_org];
    assign w_expired      = w_tracing && (w_new == '0) &&
                            (r_tcnt == TIMEOUT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_org          <= '0;
            r_visited      <= '0;
            r_reported     <= '0;
            r_tcnt         <= '0;
            r_timeout_flag <= 1'b0;
            r_dl_global    <= 1'b0;
            r_origin_vec   <= '0;
            r_token_clear  <= 1'b0;
            r_valid        <= 1'b0;
            r_id           <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_mask         <= '0;
        end else begin
            // A presented id is held until the consumer takes it.
            if (w_stream) begin
                r_visited  <= w_visited_nxt;
                r_reported <= w_reported_nxt;
                if (!r_valid || report_ready) begin
                    r_valid <= w_pick_found;
                    r_id    <= w_pick_idx;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_org_found) begin
                        r_org        <= w_org_idx;
                        r_origin_vec <= w_org_onehot;
                        r_dl_global  <= 1'b1;
                        r_visited    <= w_org_onehot;
                        r_state      <= ORIGIN;
                    end
                end
                ORIGIN: begin
                    r_origin_vec <= '0;
                    r_tcnt       <= '0;
                    r_state      <= TRACE;
                end
                TRACE: begin
                    if (w_new != '0) begin
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TIMEOUT_W'(1);
                    end
                    if (w_closed || w_expired) begin
                        r_token_clear  <= 1'b1;
                        r_timeout_flag <= !w_closed;
                        r_state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_token_clear <= 1'b0;
                    r_state       <= DRAIN;
                end
                DRAIN: begin
                    if (w_pending == '0) begin
                        r_done    <= 1'b1;
                        r_mask    <= r_visited;
                        r_timeout <= r_timeout_flag;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (report_ack) begin
                        r_visited      <= '0;
                        r_reported     <= '0;
                        r_tcnt         <= '0;
                        r_timeout_flag <= 1'b0;
                        r_dl_global    <= 1'b0;
                        r_valid        <= 1'b0;
                        r_id           <= '0;
                        r_done         <= 1'b0;
                        r_timeout      <= 1'b0;
                        r_mask         <= '0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dl_detect_global  = r_dl_global;
    assign origin_vec        = r_origin_vec;
    assign token_clear       = r_token_clear;
    assign report_valid      = r_valid;
    assign report_proc_id    = r_id;
    assign report_done       = r_done;
    assign report_timeout    = r_timeout;
    assign report_cycle_mask = r_mask;

endmodule

`default_nettype wire
